// File: rtl/queue_detector_if.sv
// Loop-detector inputs and queue-status outputs shared between the
// intersection controller side and the queue_detector front end.
interface queue_detector_if #(
  parameter int unsigned CNT_W = 4
);
  logic             arrM;
  logic             depM;
  logic             arrC;
  logic             depC;
  logic             PQm;
  logic             PQc;
  logic [CNT_W-1:0] cntM;
  logic [CNT_W-1:0] cntC;
  logic             satM;
  logic             satC;

  modport master (
    output arrM, depM, arrC, depC,
    input  PQm, PQc, cntM, cntC, satM, satC
  );

  modport slave (
    input  arrM, depM, arrC, depC,
    output PQm, PQc, cntM, cntC, satM, satC
  );
endinterface

// File: rtl/queue_detector.sv
// Vehicle-queue front end: synchronizes and debounces four loop detectors,
// keeps a saturating waiting count per road and flags queue presence.
module queue_detector #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned THRESH   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  queue_detector_if.slave   bus
);

  localparam int unsigned NCH     = 4;
  localparam int unsigned ARR_M   = 0;
  localparam int unsigned DEP_M   = 1;
  localparam int unsigned ARR_C   = 2;
  localparam int unsigned DEP_C   = 3;
  localparam logic [7:0]       DC_LAST = 8'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

  logic [NCH-1:0] raw_c;
  logic [NCH-1:0] sync_q1;
  logic [NCH-1:0] sync_q2;
  logic [NCH-1:0] deb_q;
  logic [NCH-1:0] deb_d_q;
  logic [NCH-1:0] ev_c;
  logic [7:0]     dc_q [NCH];

  logic [CNT_W-1:0] cnt_m_q, cnt_c_q;
  logic             sat_m_q, sat_c_q;
  logic             pq_m_q, pq_c_q;
  logic [CNT_W:0]   road_m_c, road_c_c;

  assign raw_c = {bus.depC, bus.arrC, bus.depM, bus.arrM};

  // Two-flop synchronizer per channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= raw_c;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce: level changes only after DEBOUNCE consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q   <= '0;
      deb_d_q <= '0;
      for (int i = 0; i < NCH; i++) dc_q[i] <= '0;
    end else begin
      deb_d_q <= deb_q;
      for (int i = 0; i < NCH; i++) begin
        if (sync_q2[i] == deb_q[i]) begin
          dc_q[i] <= '0;
        end else if (dc_q[i] == DC_LAST) begin
          deb_q[i] <= sync_q2[i];
          dc_q[i]  <= '0;
        end else begin
          dc_q[i] <= dc_q[i] + 8'd1;
        end
      end
    end
  end

  assign ev_c = deb_q & ~deb_d_q;

  // Next {sat, count} for one road; simultaneous arrival+departure cancel
  function automatic logic [CNT_W:0] road_next(
    input logic             arr,
    input logic             dep,
    input logic [CNT_W-1:0] cnt,
    input logic             sat
  );
    logic [CNT_W-1:0] c;
    logic             s;
    c = cnt;
    s = sat;
    if (arr && !dep) begin
      if (cnt == CNT_MAX) s = 1'b1;
      else                c = cnt + CNT_W'(1);
    end else if (dep && !arr && (cnt != '0)) begin
      c = cnt - CNT_W'(1);
    end
    return {s, c};
  endfunction

  always_comb begin
    road_m_c = {sat_m_q, cnt_m_q};
    road_c_c = {sat_c_q, cnt_c_q};
    road_m_c = road_next(ev_c[ARR_M], ev_c[DEP_M], cnt_m_q, sat_m_q);
    road_c_c = road_next(ev_c[ARR_C], ev_c[DEP_C], cnt_c_q, sat_c_q);
  end

  // Per-road counters, sticky saturation and queue-present flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_m_q <= '0;
      cnt_c_q <= '0;
      sat_m_q <= 1'b0;
      sat_c_q <= 1'b0;
      pq_m_q  <= 1'b0;
      pq_c_q  <= 1'b0;
    end else begin
      {sat_m_q, cnt_m_q} <= road_m_c;
      {sat_c_q, cnt_c_q} <= road_c_c;
      pq_m_q <= (cnt_m_q >= THR);
      pq_c_q <= (cnt_c_q >= THR);
    end
  end

  assign bus.cntM = cnt_m_q;
  assign bus.cntC = cnt_c_q;
  assign bus.satM = sat_m_q;
  assign bus.satC = sat_c_q;
  assign bus.PQm  = pq_m_q;
  assign bus.PQc  = pq_c_q;

endmodule

// File: tb/tb_queue_detector.sv
// Directed bench for queue_detector: table of input phases with expected
// outputs, plus edge-exact sequences for latency, saturation, reset and threshold.
module tb_queue_detector;

  logic clk;
  logic rst_n;
  int   checks;
  int   errs;

  queue_detector_if #(.CNT_W(4)) bus ();
  queue_detector_if #(.CNT_W(4)) bus3 ();

  queue_detector #(.DEBOUNCE(4), .CNT_W(4), .THRESH(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  queue_detector #(.DEBOUNCE(4), .CNT_W(4), .THRESH(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] in;   // {depC, arrC, depM, arrM}
    int         cyc;
    int         cm;
    int         cc;
    int         pm;
    int         pc;
    int         sm;
    int         sc;
  } vec_t;

  vec_t tbl [19];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input logic [3:0] v);
    {bus.depC, bus.arrC, bus.depM, bus.arrM} = v;
  endtask

  task automatic set_in3(input logic [3:0] v);
    {bus3.depC, bus3.arrC, bus3.depM, bus3.arrM} = v;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int cm, input int cc,
                         input int pm, input int pc, input int sm, input int sc);
    chk({name, ".cntM"}, int'(bus.cntM), cm);
    chk({name, ".cntC"}, int'(bus.cntC), cc);
    chk({name, ".PQm"},  int'(bus.PQm),  pm);
    chk({name, ".PQc"},  int'(bus.PQc),  pc);
    chk({name, ".satM"}, int'(bus.satM), sm);
    chk({name, ".satC"}, int'(bus.satC), sc);
  endtask

  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      set_in(tbl[i].in);
      tick(tbl[i].cyc);
      chk_out(tbl[i].name, tbl[i].cm, tbl[i].cc, tbl[i].pm, tbl[i].pc,
              tbl[i].sm, tbl[i].sc);
    end
  endtask

  task automatic pulse(input logic [3:0] v);
    set_in(v);
    tick(8);
    set_in(4'b0000);
    tick(8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    checks = 0;
    errs   = 0;

    //         name          in      cyc cm cc pm pc sm sc
    tbl[0]  = '{"idle",      4'b0000, 4, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{"glitch_hi", 4'b0100, 3, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{"glitch_lo", 4'b0000, 8, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{"udf_hi",    4'b0010, 8, 0, 1, 0, 1, 0, 0};
    tbl[4]  = '{"udf_lo",    4'b0000, 8, 0, 1, 0, 1, 0, 0};
    tbl[5]  = '{"both_arr",  4'b0101, 8, 1, 2, 1, 1, 0, 0};
    tbl[6]  = '{"both_lo",   4'b0000, 8, 1, 2, 1, 1, 0, 0};
    tbl[7]  = '{"depc1",     4'b1000, 8, 1, 1, 1, 1, 0, 0};
    tbl[8]  = '{"depc1_lo",  4'b0000, 8, 1, 1, 1, 1, 0, 0};
    tbl[9]  = '{"depc2",     4'b1000, 8, 1, 0, 1, 0, 0, 0};
    tbl[10] = '{"depc2_lo",  4'b0000, 8, 1, 0, 1, 0, 0, 0};
    tbl[11] = '{"arrm",      4'b0001, 8, 2, 0, 1, 0, 0, 0};
    tbl[12] = '{"arrm_lo",   4'b0000, 8, 2, 0, 1, 0, 0, 0};
    tbl[13] = '{"simul",     4'b0011, 8, 2, 0, 1, 0, 0, 0};
    tbl[14] = '{"simul_lo",  4'b0000, 8, 2, 0, 1, 0, 0, 0};
    tbl[15] = '{"depm1",     4'b0010, 8, 1, 0, 1, 0, 0, 0};
    tbl[16] = '{"depm1_lo",  4'b0000, 8, 1, 0, 1, 0, 0, 0};
    tbl[17] = '{"depm2",     4'b0010, 8, 0, 0, 0, 0, 0, 0};
    tbl[18] = '{"depm2_lo",  4'b0000, 8, 0, 0, 0, 0, 0, 0};

    rst_n = 1'b0;
    set_in(4'b0000);
    set_in3(4'b0000);
    tick(2);
    chk_out("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    run_rows(0, 2);

    // Clean arrival: count at edge 7, flag at edge 8
    set_in(4'b0100);
    for (int e = 1; e <= 10; e++) begin
      tick(1);
      chk($sformatf("lat_e%0d.cntC", e), int'(bus.cntC), (e >= 7) ? 1 : 0);
      chk($sformatf("lat_e%0d.PQc", e),  int'(bus.PQc),  (e >= 8) ? 1 : 0);
    end
    set_in(4'b0000);
    tick(8);

    run_rows(3, 18);

    // Saturation on the main road
    for (int p = 1; p <= 16; p++) begin
      set_in(4'b0001);
      tick(8);
      chk($sformatf("sat_p%0d.cntM", p), int'(bus.cntM), (p < 15) ? p : 15);
      chk($sformatf("sat_p%0d.satM", p), int'(bus.satM), (p == 16) ? 1 : 0);
      set_in(4'b0000);
      tick(8);
    end
    for (int d = 0; d < 3; d++) pulse(4'b0010);
    chk_out("sat_dep", 12, 0, 1, 0, 1, 0);

    // Asynchronous reset in the middle of a debounce
    set_in(4'b0001);
    tick(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0, 0, 0, 0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("post_rst_e6.cntM", int'(bus.cntM), 0);
    tick(1);
    chk("post_rst_e7.cntM", int'(bus.cntM), 1);
    chk("post_rst_e7.PQm",  int'(bus.PQm),  0);
    tick(1);
    chk("post_rst_e8.PQm",  int'(bus.PQm),  1);
    set_in(4'b0000);
    tick(8);

    // Threshold of 3 on the second instance, with main-road traffic alongside
    for (int p = 1; p <= 3; p++) begin
      set_in3(4'b0101);
      tick(6);
      chk($sformatf("thr_p%0d_e6.cntC", p), int'(bus3.cntC), p - 1);
      tick(1);
      chk($sformatf("thr_p%0d_e7.cntC", p), int'(bus3.cntC), p);
      chk($sformatf("thr_p%0d_e7.PQc", p),  int'(bus3.PQc),  0);
      tick(1);
      chk($sformatf("thr_p%0d_e8.PQc", p),  int'(bus3.PQc),  (p >= 3) ? 1 : 0);
      set_in3(4'b0000);
      tick(8);
    end
    chk("thr.cntM", int'(bus3.cntM), 3);
    chk("thr.PQm",  int'(bus3.PQm),  1);
    set_in3(4'b1010);
    tick(7);
    chk("thr_dep_e7.cntC", int'(bus3.cntC), 2);
    chk("thr_dep_e7.PQc",  int'(bus3.PQc),  1);
    tick(1);
    chk("thr_dep_e8.PQc",  int'(bus3.PQc),  0);
    chk("thr_dep_e8.cntM", int'(bus3.cntM), 2);
    chk("thr_dep_e8.PQm",  int'(bus3.PQm),  0);
    set_in3(4'b0000);
    tick(8);
    chk("thr_end.cntC", int'(bus3.cntC), 2);
    chk("thr_end.satC", int'(bus3.satC), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
